// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate checker and related shifter blocks.
//   state_e       : checker FSM states
//   DEFAULT_WIDTH : default data word width
//   ERR_MAX       : saturation value of the mismatch counter
//   ROT_RIGHT/LEFT: one-bit direction encodings
package rotate_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [15:0] ERR_MAX       = 16'hFFFF;

  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    COMPARE
  } state_e;

endpackage

// File: rtl/rotate_step.sv
// Combinational rotate of a word by exactly one bit position.
//   data_in  : word to rotate
//   dir_in   : ROT_RIGHT (0) or ROT_LEFT (1)
//   data_out : rotated word, no bits lost
module rotate_step
  import rotate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir_in,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    if (dir_in == ROT_LEFT) begin
      data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
    end else begin
      data_out = {data_in[0], data_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rotate_inverse_checker.sv
// Undoes a shifter rotation one bit per clock and compares against the original word.
//   clk_in, reset_in : clock, synchronous active-high reset
//   start_in         : request, accepted when ready_out is high
//   shifted_in       : rotated word from the shifter
//   amt_in, dir_in   : rotate amount and direction that produced shifted_in
//   expected_in      : original pre-rotation word
//   clear_err_in     : synchronous clear of the mismatch counter (wins over increment)
//   ready_out        : high in IDLE
//   done_out         : one-cycle result strobe
//   pass_out         : restored word matched expected (held until next done_out)
//   restored_out     : inverse-rotated word (held until next done_out)
//   err_count_out    : saturating mismatch count
module rotate_inverse_checker
  import rotate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] shifted_in,
  input  logic [AMT_W-1:0] amt_in,
  input  logic             dir_in,
  input  logic [WIDTH-1:0] expected_in,
  input  logic             clear_err_in,
  output logic             ready_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [WIDTH-1:0] restored_out,
  output logic [15:0]      err_count_out
);

  localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] rest_q, rest_d;
  logic [15:0]      err_q, err_d;

  logic             undo_dir;
  logic [WIDTH-1:0] step_out;
  logic             finish;
  logic [WIDTH-1:0] final_word;
  logic [WIDTH-1:0] final_exp;
  logic             match;

  // Undo the shifter: it rotated right, so we rotate left, and vice versa.
  assign undo_dir = (dir_q == ROT_RIGHT) ? ROT_LEFT : ROT_RIGHT;

  rotate_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_in  (work_q),
    .dir_in   (undo_dir),
    .data_out (step_out)
  );

  // The result registers load on the edge that enters COMPARE, so done_out,
  // restored_out and pass_out are all valid during the COMPARE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    exp_d      = exp_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    rest_d     = rest_q;
    err_d      = err_q;
    finish     = 1'b0;
    final_word = work_q;
    final_exp  = exp_q;
    match      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          work_d = shifted_in;
          exp_d  = expected_in;
          dir_d  = dir_in;
          cnt_d  = amt_in;
          if (amt_in == '0) begin
            state_d    = COMPARE;
            finish     = 1'b1;
            final_word = shifted_in;
            final_exp  = expected_in;
          end else begin
            state_d = ROTATE;
          end
        end
      end
      ROTATE: begin
        work_d = step_out;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d    = COMPARE;
          finish     = 1'b1;
          final_word = step_out;
        end
      end
      COMPARE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      match  = (final_word == final_exp);
      done_d = 1'b1;
      rest_d = final_word;
      pass_d = match;
      if (!match && (err_q != ERR_MAX)) begin
        err_d = err_q + 16'd1;
      end
    end

    if (clear_err_in) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      exp_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      rest_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      exp_q   <= exp_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      rest_q  <= rest_d;
      err_q   <= err_d;
    end
  end

  assign ready_out     = (state_q == IDLE);
  assign done_out      = done_q;
  assign pass_out      = pass_q;
  assign restored_out  = rest_q;
  assign err_count_out = err_q;

endmodule

// File: tb/tb_rotate_inverse_checker.sv
module tb_rotate_inverse_checker;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  shifted;
  logic [2:0]  amt;
  logic        dir;
  logic [7:0]  expected;
  logic        clear_err;
  logic        ready;
  logic        done;
  logic        pass;
  logic [7:0]  restored;
  logic [15:0] err_count;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] model_err = '0;

  rotate_inverse_checker #(
    .WIDTH (8),
    .AMT_W (3)
  ) dut (
    .clk_in        (clk),
    .reset_in      (reset),
    .start_in      (start),
    .shifted_in    (shifted),
    .amt_in        (amt),
    .dir_in        (dir),
    .expected_in   (expected),
    .clear_err_in  (clear_err),
    .ready_out     (ready),
    .done_out      (done),
    .pass_out      (pass),
    .restored_out  (restored),
    .err_count_out (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sh;
    logic [2:0] a;
    logic       d;
    logic [7:0] ex;
    logic [7:0] rest;
    logic       ok;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [7:0] rol8(input logic [7:0] x, input int a);
    logic [15:0] t;
    t = {x, x} << a;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ror8(input logic [7:0] x, input int a);
    logic [15:0] t;
    t = {x, x} >> a;
    return t[7:0];
  endfunction

  // dir=0 means the shifter rotated right, so the original is recovered by rotating left.
  function automatic logic [7:0] undo(input logic [7:0] x, input int a, input logic d);
    return d ? ror8(x, a) : rol8(x, a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic run_req(input logic [7:0] sh, input logic [2:0] a, input logic d,
                         input logic [7:0] ex, input logic [7:0] exp_rest,
                         input logic exp_ok, input string tag);
    int cycles;
    bit got;
    if (clear_err) model_err = '0;
    else if (!exp_ok && model_err != 16'hFFFF) model_err++;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(ready), 32'd1);
    start = 1'b1; shifted = sh; amt = a; dir = d; expected = ex;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check({tag, " ready_low"}, 32'(ready), 32'd0);
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(cycles), 32'(a) + 32'd1);
    check({tag, " restored"}, 32'(restored), 32'(exp_rest));
    check({tag, " pass"}, 32'(pass), 32'(exp_ok));
    check({tag, " err_count"}, 32'(err_count), 32'(model_err));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [7:0] orig, sh, ex, r;
    logic [2:0] a;
    logic       d;
    int         cycles;
    bit         seen;

    vecs[0] = '{8'h3C, 3'd2, 1'b0, 8'hF0, 8'hF0, 1'b1};
    vecs[1] = '{8'hC3, 3'd2, 1'b1, 8'hF0, 8'hF0, 1'b1};
    vecs[2] = '{8'hA5, 3'd0, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[3] = '{8'h4B, 3'd7, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[4] = '{8'h81, 3'd1, 1'b0, 8'h03, 8'h03, 1'b1};
    vecs[5] = '{8'h01, 3'd7, 1'b1, 8'h02, 8'h02, 1'b1};
    vecs[6] = '{8'h3C, 3'd2, 1'b0, 8'hF1, 8'hF0, 1'b0};

    reset = 1'b1; start = 1'b0; shifted = '0; amt = '0; dir = 1'b0;
    expected = '0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst restored", 32'(restored), 32'd0);
    check("rst err", 32'(err_count), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].sh, vecs[i].a, vecs[i].d, vecs[i].ex, vecs[i].rest, vecs[i].ok,
              $sformatf("vec%0d", i));
    end

    // Clear asserted across a second mismatch: clear wins, count ends at zero.
    clear_err = 1'b1;
    run_req(8'h3C, 3'd2, 1'b0, 8'hF1, 8'hF0, 1'b0, "clear_vs_mismatch");
    clear_err = 1'b0;
    run_req(8'h3C, 3'd2, 1'b0, 8'hF1, 8'hF0, 1'b0, "mismatch_after_clear");

    // start pulsed during ROTATE must be ignored and must not disturb captured data.
    @(negedge clk);
    start = 1'b1; shifted = 8'h0F; amt = 3'd3; dir = 1'b1; expected = 8'hE1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; shifted = 8'hFF; amt = 3'd1; dir = 1'b0; expected = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b0;
    cycles = 3;
    seen = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    check("ignore_start latency", 32'(cycles), 32'd4);
    check("ignore_start restored", 32'(restored), 32'(undo(8'h0F, 3, 1'b1)));
    check("ignore_start pass", 32'(pass), 32'd1);
    @(negedge clk);
    check("ignore_start ready", 32'(ready), 32'd1);

    // Reset in the second cycle of an amt=5 request.
    @(negedge clk);
    start = 1'b1; shifted = 8'h12; amt = 3'd5; dir = 1'b0; expected = 8'h34;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_err = '0;
    @(negedge clk);
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    check("midrst pass", 32'(pass), 32'd0);
    check("midrst restored", 32'(restored), 32'd0);
    check("midrst err", 32'(err_count), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst no_done", 32'(seen), 32'd0);

    // Randomized requests checked against the arithmetic rotate model.
    for (int i = 0; i < 30; i++) begin
      orig = 8'($urandom);
      a    = 3'($urandom_range(0, 7));
      d    = 1'($urandom_range(0, 1));
      sh   = d ? rol8(orig, int'(a)) : ror8(orig, int'(a));
      ex   = ($urandom_range(0, 1) == 1) ? orig : 8'($urandom);
      r    = undo(sh, int'(a), d);
      run_req(sh, a, d, ex, r, (r == ex), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
